// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared state encoding, address shift and default memory depths
package mem_loader_pkg;
    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        RUN,
        DUMP_RD,
        DUMP_WAIT,
        FIN
    } state_t;

    localparam int ADDR_SHIFT     = 2;
    localparam int IMEM_DEPTH_DEF = 512;
    localparam int DMEM_DEPTH_DEF = 1024;
endpackage

// File: rtl/mem_loader_out_reg.sv
// mem_loader_out_reg: readback holding register with valid/ready handshake
//   load/load_data/load_last : capture a new word (only while empty)
//   out_ready                : host accepts the held word
//   out_valid/out_data/out_last : held word, stable until accepted
module mem_loader_out_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;

    always_comb begin
        valid_d = load | (valid_q & ~out_ready);
        data_d  = load ? load_data : data_q;
        last_d  = load ? load_last : last_q & ~(valid_q & out_ready);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
endmodule

// File: rtl/mem_loader.sv
// mem_loader: host-side loader that fills imem/dmem, runs the cpu, and dumps dmem
//   start/run_cycles/dump_words : job control, latched in IDLE
//   in_*                        : host word stream (program segment, then data segment)
//   out_*                       : dmem readback stream
//   busy/done/overflow/enable   : status and cpu enable
//   *_ext                       : imem external port, *_ext_2 : dmem external port
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF,
    parameter int DMEM_DEPTH = DMEM_DEPTH_DEF,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic [CNT_W-1:0]  dump_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic              enable,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [DATA_W-1:0] wdata_ext,
    input  logic [DATA_W-1:0] rdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [DATA_W-1:0] wdata_ext_2,
    input  logic [DATA_W-1:0] rdata_ext_2
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d, run_q, run_d, dump_q, dump_d;
    logic             ovf_q, ovf_d, enable_q, busy_q, done_q;
    logic             ld_i, ld_d, rd, hs, i_ovf, d_ovf, last_word, load_out;
    logic [31:0]      byte_addr;
    state_t           post_run;
    logic             unused_rdata;

    assign unused_rdata = ^rdata_ext;
    assign ld_i      = state_q == LOAD_I;
    assign ld_d      = state_q == LOAD_D;
    assign rd        = state_q == DUMP_RD;
    assign in_ready  = ld_i | ld_d;
    assign hs        = in_valid & in_ready;
    assign i_ovf     = idx_q >= CNT_W'(IMEM_DEPTH);
    assign d_ovf     = idx_q >= CNT_W'(DMEM_DEPTH);
    assign byte_addr = 32'(idx_q) << ADDR_SHIFT;
    assign last_word = idx_q == dump_q - CNT_W'(1);
    assign post_run  = (dump_q == '0) ? FIN : DUMP_RD;

    // Memory strobes are combinational so a host word is written in its handshake cycle.
    assign wen_ext     = ld_i & hs & ~i_ovf;
    assign ren_ext     = 1'b0;
    assign addr_ext    = ld_i ? byte_addr : '0;
    assign wdata_ext   = ld_i ? in_data : '0;
    assign wen_ext_2   = ld_d & hs & ~d_ovf;
    assign ren_ext_2   = rd & ~d_ovf;
    assign addr_ext_2  = (ld_d | rd) ? byte_addr : '0;
    assign wdata_ext_2 = ld_d ? in_data : '0;

    // Capture happens in the first DUMP_WAIT cycle, when the holding register is still empty.
    assign load_out = (state_q == DUMP_WAIT) & ~out_valid;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        dump_d  = dump_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                run_d   = run_cycles;
                dump_d  = dump_words;
                idx_d   = '0;
                ovf_d   = 1'b0;
                state_d = LOAD_I;
            end
            LOAD_I: if (hs) begin
                ovf_d   = ovf_q | i_ovf;
                idx_d   = in_last ? '0 : idx_q + CNT_W'(1);
                state_d = in_last ? LOAD_D : LOAD_I;
            end
            LOAD_D: if (hs) begin
                ovf_d   = ovf_q | d_ovf;
                idx_d   = in_last ? '0 : idx_q + CNT_W'(1);
                cnt_d   = run_q;
                state_d = !in_last ? LOAD_D : (run_q == '0) ? post_run : RUN;
            end
            RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    idx_d   = '0;
                    state_d = post_run;
                end
            end
            DUMP_RD: begin
                ovf_d   = ovf_q | d_ovf;
                state_d = DUMP_WAIT;
            end
            DUMP_WAIT: if (out_valid && out_ready) begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = last_word ? FIN : DUMP_RD;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            run_q    <= '0;
            dump_q   <= '0;
            ovf_q    <= 1'b0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            dump_q   <= dump_d;
            ovf_q    <= ovf_d;
            enable_q <= state_d == RUN;
            busy_q   <= state_d != IDLE;
            done_q   <= state_d == FIN;
        end
    end

    assign enable   = enable_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

    mem_loader_out_reg #(.DATA_W(DATA_W)) u_out_reg (
        .clk      (clk),
        .arst_n   (arst_n),
        .load     (load_out),
        .load_data(d_ovf ? '0 : rdata_ext_2),
        .load_last(last_word),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_last (out_last)
    );
endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: directed bench for mem_loader with a dmem model and port monitors
module tb_mem_loader;
    logic        clk = 1'b0, arst_n = 1'b0, start = 1'b0;
    logic [31:0] run_cycles = '0, dump_words = '0;
    logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_valid, out_ready = 1'b0, out_last;
    logic [31:0] out_data;
    logic        busy, done, overflow, enable;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext = '0, rdata_ext_2 = '0;

    int checks = 0, errors = 0;
    int cyc = 0, en_cnt = 0, en_runs = 0, done_cnt = 0, excl_viol = 0, stall_viol = 0, stalls = 0;
    logic en_prev = 1'b0, hold_v = 1'b0, pat_en = 1'b0;
    logic [32:0] hold_d = '0;
    int pat_i = 0;
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] dmem [16];
    logic [31:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$], od[$];
    int          iw_cyc[$];
    logic        ol[$];

    mem_loader #(.DATA_W(32), .IMEM_DEPTH(4), .DMEM_DEPTH(8), .CNT_W(32)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .run_cycles(run_cycles), .dump_words(dump_words),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .done(done), .overflow(overflow), .enable(enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wen_ext_2) dmem[addr_ext_2[5:2]] <= wdata_ext_2;
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[5:2]];
    end

    always @(posedge clk) begin
        #1;
        if (pat_en) begin
            out_ready = pat[pat_i];
            pat_i = (pat_i + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (wen_ext) begin iw_addr.push_back(addr_ext); iw_data.push_back(wdata_ext); iw_cyc.push_back(cyc); end
        if (wen_ext_2) begin dw_addr.push_back(addr_ext_2); dw_data.push_back(wdata_ext_2); end
        if (enable) en_cnt++;
        if (enable && !en_prev) en_runs++;
        en_prev = enable;
        if (done) done_cnt++;
        if ((wen_ext_2 && ren_ext_2) || ((wen_ext || ren_ext) && (wen_ext_2 || ren_ext_2)) ||
            (enable && (wen_ext || wen_ext_2 || ren_ext_2))) excl_viol++;
        if (out_valid && out_ready) begin od.push_back(out_data); ol.push_back(out_last); end
        if (hold_v && out_valid && {out_last, out_data} !== hold_d) stall_viol++;
        hold_v = out_valid && !out_ready;
        hold_d = {out_last, out_data};
        if (hold_v) stalls++;
    end

    task automatic clear_logs();
        iw_addr.delete(); iw_data.delete(); iw_cyc.delete(); dw_addr.delete(); dw_data.delete();
        od.delete(); ol.delete();
        en_cnt = 0; en_runs = 0; done_cnt = 0; stall_viol = 0; stalls = 0;
    endtask

    task automatic start_job(input logic [31:0] rc, input logic [31:0] dw);
        start = 1'b1; run_cycles = rc; dump_words = dw;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        bit ok = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL send_word in_ready never seen for word %0h", d); end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_done timeout got done=0 want done=1"); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy, done, enable, in_ready, out_valid, out_last, overflow, wen_ext, ren_ext, wen_ext_2, ren_ext_2} !== 11'b0) begin
            errors++; $display("FAIL reset_flags got %b want 0", {busy, done, enable, in_ready, out_valid, out_last, overflow, wen_ext, ren_ext, wen_ext_2, ren_ext_2});
        end
        checks++;
        if ({addr_ext, addr_ext_2, out_data} !== 96'b0) begin
            errors++; $display("FAIL reset_data got %h want 0", {addr_ext, addr_ext_2, out_data});
        end
        @(posedge clk); #1; arst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_load();
        clear_logs();
        start_job(32'd2, 32'd0);
        send_word(32'h20010005, 1'b0);
        send_word(32'h20020007, 1'b0);
        send_word(32'h00221820, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        checks++;
        if (en_cnt !== 0) begin errors++; $display("FAIL load_no_enable got %0d want 0", en_cnt); end
        checks++;
        if (iw_addr.size() != 3 || iw_addr[0] !== 32'h0 || iw_addr[1] !== 32'h4 || iw_addr[2] !== 32'h8) begin
            errors++; $display("FAIL load_imem_addr got n=%0d want 0,4,8", iw_addr.size());
        end
        checks++;
        if (iw_cyc.size() != 3 || iw_cyc[1] != iw_cyc[0] + 1 || iw_cyc[2] != iw_cyc[0] + 2) begin
            errors++; $display("FAIL load_imem_consecutive got n=%0d want 3 consecutive cycles", iw_cyc.size());
        end
        checks++;
        if (iw_data.size() != 3 || iw_data[0] !== 32'h20010005 || iw_data[2] !== 32'h00221820) begin
            errors++; $display("FAIL load_imem_data got n=%0d want program words", iw_data.size());
        end
        checks++;
        if (dw_addr.size() != 1 || dw_addr[0] !== 32'h0 || dw_data[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL load_dmem got n=%0d want one write 0xDEADBEEF at 0x0", dw_addr.size());
        end
        wait_done();
        checks++;
        if (en_cnt !== 2 || done_cnt !== 1) begin errors++; $display("FAIL load_job got en=%0d done=%0d want 2,1", en_cnt, done_cnt); end
    endtask

    task automatic test_run_window();
        clear_logs();
        start_job(32'd10, 32'd0);
        send_word(32'h1, 1'b1);
        send_word(32'h2, 1'b1);
        wait_done();
        checks++;
        if (en_cnt !== 10 || en_runs !== 1) begin errors++; $display("FAIL run10 got cycles=%0d runs=%0d want 10,1", en_cnt, en_runs); end
        clear_logs();
        start_job(32'd0, 32'd0);
        send_word(32'h1, 1'b1);
        send_word(32'h2, 1'b1);
        wait_done();
        checks++;
        if (en_cnt !== 0 || done_cnt !== 1) begin errors++; $display("FAIL run0 got en=%0d done=%0d want 0,1", en_cnt, done_cnt); end
    endtask

    task automatic test_dump();
        clear_logs();
        pat_i = 0; pat_en = 1'b1;
        start_job(32'd1, 32'd4);
        send_word(32'h0, 1'b1);
        send_word(32'd1, 1'b0);
        send_word(32'd2, 1'b0);
        send_word(32'd3, 1'b0);
        send_word(32'd4, 1'b1);
        wait_done();
        pat_en = 1'b0; out_ready = 1'b0;
        checks++;
        if (od.size() != 4 || od[0] !== 32'd1 || od[1] !== 32'd2 || od[2] !== 32'd3 || od[3] !== 32'd4) begin
            errors++; $display("FAIL dump_data got n=%0d first=%0h want 1,2,3,4", od.size(), od.size() ? od[0] : 32'hx);
        end
        checks++;
        if (ol.size() != 4 || {ol[0], ol[1], ol[2], ol[3]} !== 4'b0001) begin
            errors++; $display("FAIL dump_last got n=%0d want only last word flagged", ol.size());
        end
        checks++;
        if (stall_viol !== 0 || stalls == 0) begin errors++; $display("FAIL dump_hold got viol=%0d stalls=%0d want 0,>0", stall_viol, stalls); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL dump_done got %0d want 1", done_cnt); end
    endtask

    task automatic test_overflow();
        clear_logs();
        start_job(32'd1, 32'd0);
        for (int i = 0; i < 6; i++) send_word(32'h100 + i, i == 5);
        send_word(32'h9, 1'b1);
        wait_done();
        checks++;
        if (iw_addr.size() != 4 || iw_addr[3] !== 32'hC) begin errors++; $display("FAIL ovf_writes got n=%0d want 4 ending 0xC", iw_addr.size()); end
        checks++;
        if (overflow !== 1'b1 || done_cnt !== 1) begin errors++; $display("FAIL ovf_flag got ovf=%b done=%0d want 1,1", overflow, done_cnt); end
    endtask

    task automatic test_start_busy();
        clear_logs();
        start_job(32'd4, 32'd0);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL start_clears_ovf got %b want 0", overflow); end
        send_word(32'h1, 1'b1);
        start_job(32'd9, 32'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL busy_start got busy=%b ready=%b want 1,1", busy, in_ready); end
        send_word(32'h2, 1'b1);
        wait_done();
        checks++;
        if (en_cnt !== 4 || od.size() != 0 || done_cnt !== 1) begin
            errors++; $display("FAIL busy_latch got en=%0d dump=%0d done=%0d want 4,0,1", en_cnt, od.size(), done_cnt);
        end
    endtask

    task automatic test_reset_run();
        bit seen = 0;
        clear_logs();
        start_job(32'd50, 32'd0);
        send_word(32'h1, 1'b1);
        send_word(32'h2, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (enable) begin seen = 1; break; end
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_run_enable timeout got 0 want 1"); end
        repeat (3) @(posedge clk);
        #3; arst_n = 1'b0; #1;
        checks++;
        if ({enable, busy, in_ready, done, wen_ext, wen_ext_2} !== 6'b0) begin
            errors++; $display("FAIL rst_run_abort got %b want 0", {enable, busy, in_ready, done, wen_ext, wen_ext_2});
        end
        @(posedge clk); #1; arst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || enable !== 1'b0) begin errors++; $display("FAIL rst_run_idle got busy=%b en=%b want 0,0", busy, enable); end
        clear_logs();
        out_ready = 1'b1;
        start_job(32'd3, 32'd1);
        send_word(32'h7, 1'b1);
        send_word(32'h55, 1'b1);
        wait_done();
        out_ready = 1'b0;
        checks++;
        if (en_cnt !== 3 || done_cnt !== 1) begin errors++; $display("FAIL rst_clean_run got en=%0d done=%0d want 3,1", en_cnt, done_cnt); end
        checks++;
        if (od.size() != 1 || od[0] !== 32'h55 || ol[0] !== 1'b1) begin
            errors++; $display("FAIL rst_clean_dump got n=%0d want one word 0x55 with last", od.size());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_run_window();
        test_dump();
        test_overflow();
        test_start_busy();
        test_reset_run();
        checks++;
        if (excl_viol !== 0) begin errors++; $display("FAIL port_exclusive got %0d want 0", excl_viol); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
